// File: rtl/cl_pattern_timing.sv
// cl_pattern_timing
// Test-pattern video timing generator. Uses the upstream free-running 10-bit
// pixel counter as the horizontal position and produces registered
// CameraLink-style FVAL/LVAL/DVAL strobes, an 8-bit test pattern and
// line/frame bookkeeping. Every line or state transition happens on the
// end-of-line position (count_in == 1023).
module cl_pattern_timing #(
  parameter int unsigned H_ACTIVE = 640,  // active pixels per line, 1..1023
  parameter int unsigned V_ACTIVE = 480,  // active lines per frame, 1..1023
  parameter int unsigned V_BLANK  = 10    // blank lines per frame,  1..1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] count_in,
  input  logic       enable,
  input  logic [1:0] mode,
  output logic       fval,
  output logic       lval,
  output logic       dval,
  output logic [7:0] pixel,
  output logic [9:0] line_num,
  output logic [7:0] frame_cnt,
  output logic       frame_done
);

  // All comparisons are 10-bit unsigned against these constants.
  localparam logic [9:0] H_LIMIT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_LAST    = 10'(V_ACTIVE - 1);
  localparam logic [9:0] B_LAST    = 10'(V_BLANK - 1);
  localparam logic [9:0] EOL_POS   = 10'd1023;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_VBLANK = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PAT_HRAMP   = 2'd0,
    PAT_VRAMP   = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_FRAME   = 2'd3
  } pattern_e;

  // Frame-level state.
  state_e     state_q, state_d;
  logic [9:0] line_cnt_q, line_cnt_d;
  pattern_e   mode_q, mode_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       frame_done_q, frame_done_d;

  // Registered pixel-rate outputs.
  logic       fval_q, fval_d;
  logic       lval_q, lval_d;
  logic [7:0] pixel_q, pixel_d;
  logic [9:0] line_num_q;

  logic       eol;

  assign eol = (count_in == EOL_POS);

  // Frame sequencing: state, line counter, mode latch and frame counter,
  // all advanced only on the end-of-line position.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; a missing default would infer a latch.
    state_d      = state_q;
    line_cnt_d   = line_cnt_q;
    mode_d       = mode_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;

    if (eol) begin
      unique case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_d    = ST_ACTIVE;
            line_cnt_d = '0;
            mode_d     = pattern_e'(mode);
          end
        end

        ST_ACTIVE: begin
          if (line_cnt_q == V_LAST) begin
            state_d      = ST_VBLANK;
            line_cnt_d   = '0;
            frame_done_d = 1'b1;
          end else begin
            line_cnt_d = line_cnt_q + 10'd1;
          end
        end

        ST_VBLANK: begin
          if (line_cnt_q == B_LAST) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            line_cnt_d  = '0;
            // enable is only honoured here, so a dropped enable never
            // truncates a frame or its blanking.
            if (enable) begin
              state_d = ST_ACTIVE;
              mode_d  = pattern_e'(mode);
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            line_cnt_d = line_cnt_q + 10'd1;
          end
        end

        default: begin
          state_d    = ST_IDLE;
          line_cnt_d = '0;
        end
      endcase
    end
  end

  // Strobes and pattern pixel for the current position; pixel is forced to
  // zero outside the active part of an active line.
  always_comb begin
    fval_d  = (state_q == ST_ACTIVE);
    lval_d  = (state_q == ST_ACTIVE) && (count_in < H_LIMIT);
    pixel_d = 8'h00;
    if (lval_d) begin
      case (mode_q)
        PAT_HRAMP:   pixel_d = count_in[7:0];
        PAT_VRAMP:   pixel_d = line_cnt_q[7:0];
        PAT_CHECKER: pixel_d = (count_in[5] ^ line_cnt_q[5]) ? 8'hFF : 8'h00;
        PAT_FRAME:   pixel_d = frame_cnt_q;
        default:     pixel_d = 8'h00;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, so ordering of the statements below cannot matter.
    if (reset) begin
      // NOTE: every register is cleared on reset; there are no storage
      // arrays here whose contents could be left uninitialised.
      state_q      <= ST_IDLE;
      line_cnt_q   <= '0;
      mode_q       <= PAT_HRAMP;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      fval_q       <= 1'b0;
      lval_q       <= 1'b0;
      pixel_q      <= '0;
      line_num_q   <= '0;
    end else begin
      state_q      <= state_d;
      line_cnt_q   <= line_cnt_d;
      mode_q       <= mode_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
      fval_q       <= fval_d;
      lval_q       <= lval_d;
      pixel_q      <= pixel_d;
      line_num_q   <= line_cnt_q;
    end
  end

  assign fval       = fval_q;
  assign lval       = lval_q;
  assign dval       = lval_q;
  assign pixel      = pixel_q;
  assign line_num   = line_num_q;
  assign frame_cnt  = frame_cnt_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_cl_pattern_timing.sv
// tb_cl_pattern_timing
// Directed bench for cl_pattern_timing with H_ACTIVE=64, V_ACTIVE=3,
// V_BLANK=2. The bench drives count_in itself; full 1024-position lines are
// used for the pattern/timing frames, and short lines (positions jump
// straight to 1023) are used to reach the frame counter wrap quickly.
module tb_cl_pattern_timing;

  localparam int unsigned H_ACT = 64;
  localparam int unsigned V_ACT = 3;
  localparam int unsigned V_BLK = 2;

  localparam int K_RAMP    = 0;
  localparam int K_CONST   = 1;
  localparam int K_CHECKER = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] count_in;
  logic       enable;
  logic [1:0] mode;
  logic       fval, lval, dval;
  logic [7:0] pixel;
  logic [9:0] line_num;
  logic [7:0] frame_cnt;
  logic       frame_done;

  int n_vec = 0;
  int n_err = 0;

  // Passive measurements, sampled on the falling edge.
  int fval_hi  = 0;
  int lval_hi  = 0;
  int fd_hi    = 0;
  int ln_bad   = 0;
  int dval_bad = 0;

  int snap_fval, snap_lval, snap_fd;

  cl_pattern_timing #(
    .H_ACTIVE(H_ACT),
    .V_ACTIVE(V_ACT),
    .V_BLANK (V_BLK)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .count_in  (count_in),
    .enable    (enable),
    .mode      (mode),
    .fval      (fval),
    .lval      (lval),
    .dval      (dval),
    .pixel     (pixel),
    .line_num  (line_num),
    .frame_cnt (frame_cnt),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Running totals of strobe activity and bound violations.
  always @(negedge clk) begin
    if (fval === 1'b1) fval_hi <= fval_hi + 1;
    if (lval === 1'b1) lval_hi <= lval_hi + 1;
    if (frame_done === 1'b1) fd_hi <= fd_hi + 1;
    if (dval !== lval) dval_bad <= dval_bad + 1;
    if ((fval === 1'b1 && line_num > 10'(V_ACT - 1)) ||
        (fval === 1'b0 && line_num > 10'(V_BLK - 1)))
      ln_bad <= ln_bad + 1;
  end

  // Watchdog: the directed sequence is fixed length, so this only fires on a hang.
  initial begin
    #5ms;
    $display("FAIL watchdog: observed no end of sequence, expected finish before 5ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_vec++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One pixel clock at position c; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic [9:0] c);
    count_in = c;
    @(posedge clk);
    #1;
  endtask

  // Full active line with pattern checks over the active span.
  task automatic active_line(input int kind, input logic [7:0] vexp,
                             input logic [9:0] ln);
    logic [7:0] e;
    for (int c = 0; c < 1024; c++) begin
      step(10'(c));
      if (c == 0) begin
        check("fval_line_start", fval, 1);
        check("lval_line_start", lval, 1);
      end
      if (c == 10) check("line_num_active", line_num, ln);
      if (c < int'(H_ACT)) begin
        case (kind)
          K_RAMP:  e = 8'(c);
          K_CONST: e = vexp;
          default: e = (c < 32) ? 8'h00 : 8'hFF;
        endcase
        check("pixel_active", pixel, e);
      end
      if (c == int'(H_ACT)) begin
        check("lval_fall", lval, 0);
        check("dval_fall", dval, 0);
        check("pixel_after_lval", pixel, 0);
        check("fval_mid_line", fval, 1);
      end
    end
  endtask

  // Full non-active line (blanking or idle).
  task automatic blank_line(input logic [9:0] ln);
    for (int c = 0; c < 1024; c++) begin
      step(10'(c));
      if (c == 0) begin
        check("fval_blank", fval, 0);
        check("lval_blank", lval, 0);
        check("dval_blank", dval, 0);
        check("pixel_blank", pixel, 0);
        check("frame_done_clear", frame_done, 0);
      end
      if (c == 10) check("line_num_blank", line_num, ln);
    end
  endtask

  task automatic short_line();
    step(10'd0);
    step(10'd100);
    step(10'd1023);
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    mode     = 2'd0;
    count_in = 10'd0;

    // Reset state.
    step(10'd0); step(10'd1); step(10'd2);
    check("rst_fval", fval, 0);
    check("rst_lval", lval, 0);
    check("rst_pixel", pixel, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_frame_done", frame_done, 0);
    reset = 1'b0;
    step(10'd500);
    check("idle_no_enable", fval, 0);

    // Frame 1, mode 0; mode switched to 3 during line 1 must not take effect.
    snap_fval = fval_hi; snap_lval = lval_hi; snap_fd = fd_hi;
    enable = 1'b1;
    step(10'd1023);
    check("fval_before_start", fval, 0);
    active_line(K_RAMP, 8'h00, 10'd0);
    mode = 2'd3;
    active_line(K_RAMP, 8'h00, 10'd1);
    active_line(K_RAMP, 8'h00, 10'd2);
    check("frame_done_pulse", frame_done, 1);
    check("fval_last_eol", fval, 1);
    blank_line(10'd0);
    check("frame_cnt_in_blank", frame_cnt, 0);
    check("fval_total_f1", fval_hi - snap_fval, V_ACT * 1024);
    check("lval_total_f1", lval_hi - snap_lval, V_ACT * H_ACT);
    check("frame_done_count_f1", fd_hi - snap_fd, 1);
    blank_line(10'd1);
    check("frame_cnt_f1", frame_cnt, 1);

    // Frame 2, mode 3: flat frame number 1.
    active_line(K_CONST, 8'h01, 10'd0);
    mode = 2'd1;
    active_line(K_CONST, 8'h01, 10'd1);
    active_line(K_CONST, 8'h01, 10'd2);
    blank_line(10'd0);
    blank_line(10'd1);
    check("frame_cnt_f2", frame_cnt, 2);

    // Frame 3, mode 1: vertical ramp.
    active_line(K_CONST, 8'h00, 10'd0);
    mode = 2'd2;
    active_line(K_CONST, 8'h01, 10'd1);
    active_line(K_CONST, 8'h02, 10'd2);
    blank_line(10'd0);
    blank_line(10'd1);
    check("frame_cnt_f3", frame_cnt, 3);

    // Frame 4, mode 2 checker; enable dropped during line 1.
    active_line(K_CHECKER, 8'h00, 10'd0);
    enable = 1'b0;
    active_line(K_CHECKER, 8'h00, 10'd1);
    active_line(K_CHECKER, 8'h00, 10'd2);
    check("frame_done_f4", frame_done, 1);
    blank_line(10'd0);
    blank_line(10'd1);
    check("frame_cnt_f4", frame_cnt, 4);

    // Idle lines, then re-enable: fval rises 2 clks after the next EOL.
    blank_line(10'd0);
    mode   = 2'd0;
    enable = 1'b1;
    blank_line(10'd0);
    check("fval_at_restart_eol", fval, 0);

    // Frame 5, interrupted by reset on line 2.
    active_line(K_RAMP, 8'h00, 10'd0);
    active_line(K_RAMP, 8'h00, 10'd1);
    for (int c = 0; c < 30; c++) step(10'(c));
    check("pixel_before_reset", pixel, 29);
    check("line_num_before_reset", line_num, 2);
    reset = 1'b1;
    step(10'd30);
    check("midrst_fval", fval, 0);
    check("midrst_lval", lval, 0);
    check("midrst_dval", dval, 0);
    check("midrst_pixel", pixel, 0);
    check("midrst_line_num", line_num, 0);
    check("midrst_frame_cnt", frame_cnt, 0);
    check("midrst_frame_done", frame_done, 0);
    step(10'd31);
    step(10'd32);
    reset = 1'b0;
    for (int c = 33; c < 1023; c++) step(10'(c));
    check("post_rst_idle", fval, 0);
    step(10'd1023);
    check("post_rst_eol", fval, 0);
    step(10'd0);
    check("post_rst_fval_rise", fval, 1);
    check("post_rst_lval_rise", lval, 1);
    check("post_rst_line_num", line_num, 0);
    step(10'd100);
    check("short_lval_low", lval, 0);
    step(10'd1023);
    for (int l = 0; l < 4; l++) short_line();
    check("frame_cnt_short_1", frame_cnt, 1);

    // Run up to the frame counter wrap.
    for (int f = 0; f < 254; f++)
      for (int l = 0; l < 5; l++) short_line();
    check("frame_cnt_255", frame_cnt, 255);
    for (int l = 0; l < 5; l++) short_line();
    check("frame_cnt_wrap", frame_cnt, 0);

    step(10'd0);
    check("line_num_bounds", ln_bad, 0);
    check("dval_equals_lval", dval_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cl_pattern_timing.md
# cl_pattern_timing

Test-pattern video timing generator for the CameraLink receive path, directly downstream of the 10-bit free-running pixel counter. It consumes the counter value (0..1023, wrapping) as the horizontal position. From it, the block produces registered CameraLink-style FVAL/LVAL/DVAL strobes, an 8-bit test pattern pixel, and line/frame bookkeeping. Its outputs feed the capture path when no camera is attached, for bring-up and verification.

## Interface
- H_ACTIVE, 640: active pixels per line; legal 1..1023.
- V_ACTIVE, 480: active lines per frame; legal 1..1023.
- V_BLANK, 10: blank lines after each frame; legal 1..1023.
- clk  in  1  pixel clock, same clock as the upstream counter.
- reset  in  1  synchronous, active-high reset.
- count_in  in  10  horizontal position from upstream counter; increments by 1 per clk, 1023 wraps to 0.
- enable  in  1  start/continue frame generation.
- mode  in  2  pattern select: 0 horizontal ramp, 1 vertical ramp, 2 checker, 3 flat frame number.
- fval  out  1  frame valid.
- lval  out  1  line valid.
- dval  out  1  data valid; identical to lval.
- pixel  out  8  pattern data; 0 whenever lval is low.
- line_num  out  10  current line index within the current state (active or blank).
- frame_cnt  out  8  completed-frame counter, wraps 255 -> 0.
- frame_done  out  1  one-cycle pulse at the end of each active region.

## Operation
- Line boundary (EOL): the cycle in which count_in == 1023 is sampled. All state and line transitions occur only on EOL.
- FSM states and EOL transitions:
  - IDLE: if enable = 1, go to ACTIVE, clear line_cnt, latch mode into mode_q. Otherwise stay in IDLE.
  - ACTIVE: if line_cnt == V_ACTIVE-1, go to VBLANK, clear line_cnt, pulse frame_done. Otherwise increment line_cnt.
  - VBLANK: if line_cnt == V_BLANK-1, increment frame_cnt and clear line_cnt. Then go to ACTIVE (latching mode) if enable = 1, else to IDLE. Otherwise increment line_cnt.
- enable deasserted mid-frame: the current active region and its blanking complete, then the FSM enters IDLE. There is no truncated frame.
- mode is used only through mode_q. Changes to mode mid-frame take effect at the next frame start.
- Registered outputs, evaluated from the current state and count_in:
  - fval <= (state == ACTIVE).
  - lval <= (state == ACTIVE) && (count_in < H_ACTIVE).
  - dval <= the same expression as lval.
- pixel <= 0 if the lval expression is false; otherwise, by mode_q:
  - 0: count_in[7:0].
  - 1: line_cnt[7:0].
  - 2: 8'hFF if count_in[5] ^ line_cnt[5], else 8'h00.
  - 3: frame_cnt.
- line_num <= line_cnt, registered copy.
- Comparisons are 10-bit unsigned. No arithmetic wider than 10 bits is needed.
- Reset values (next edge with reset = 1): state IDLE; line_cnt, mode_q, fval, lval, dval, pixel, line_num, frame_cnt, frame_done all 0.
- Reset asserted mid-frame: outputs return to 0 on the next edge with no partial-line completion. After release, the FSM waits in IDLE for the next EOL with enable = 1.
- count_in jumping without passing through 1023 (upstream reset) causes no transition. Positions are used as sampled.

## Timing
- Latency: count_in/state to fval/lval/dval/pixel/line_num is 1 clk.
- Frame start: EOL sampled at edge N moves the FSM to ACTIVE. count_in = 0 is sampled at edge N+1; fval and lval rise together after edge N+1, and pixel 0 (count 0) is valid in the same cycle.
- lval falls 1 clk after count_in == H_ACTIVE is sampled. Each lval run is exactly H_ACTIVE cycles per line.
- frame_done: registered pulse, high for the single cycle following the last active line's EOL edge, coincident with the cycle where fval is first computed low.
- fval is high for exactly V_ACTIVE*1024 cycles, then low for at least V_BLANK*1024 cycles.
- No handshake and no backpressure. Outputs are strictly free-running relative to count_in.

## Test plan
- Reset: hold reset = 1 for 3 clks while mid-ACTIVE at line 2 -> all outputs 0 on the next edge; after release, with enable = 1, fval rises exactly 2 clks after the next count_in = 1023.
- Basic frame (H_ACTIVE=4, V_ACTIVE=3, V_BLANK=2, mode=0): lval high for 4 clks per line with pixel = 0,1,2,3; fval high for 3072 clks; frame_done is a single pulse; frame_cnt increments to 1 after the 2 blank lines.
- Pattern modes: mode=1 -> pixel equals the line index (0,1,2) on each line; mode=2 with H_ACTIVE=64 -> pixel = 00 for counts 0..31 and FF for 32..63 on line 0; mode=3 on the second frame -> pixel = 8'h01.
- Mode change mid-frame: switch mode 0 -> 1 at line 1 -> line 1 and line 2 still ramp; the new pattern starts on the next frame's line 0.
- enable drop: deassert enable during active line 1 -> the frame completes all 3 lines plus 2 blank lines, then fval stays low; re-assert -> a new frame starts 2 clks after the next EOL.
- Wrap: run 256 frames -> frame_cnt wraps 255 -> 0; line_num never exceeds V_ACTIVE-1 during ACTIVE or V_BLANK-1 during VBLANK.
